// File: rtl/scc_fetch_unit.sv
// scc fetch stage: owns the PC, issues one imem read per cycle and queues returned words.
// Define SCC_FETCH_STATS_EN to add the fetch_count / flush_count statistics outputs.
module scc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        halt_seen,
    output logic        err_misalign
`ifdef SCC_FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t DepthP = ptr_t'(DEPTH);

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    ptr_t          wptr_q, rptr_q;
    ptr_t          count;
    logic [AW+1:0] occupancy;
    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic          inflight_q;
    logic          halt_q;
    logic          err_q;
    logic [31:0]   last_data_q, last_pc_q;
    logic [31:0]   head_data, head_pc;

    logic          redirect;
    logic          issue;
    logic          capture;
    logic          pop;

    always_comb begin
        count     = wptr_q - rptr_q;
        occupancy = {1'b0, count} + {{(AW + 1){1'b0}}, inflight_q};
        redirect  = redirect_valid & clk_en;
        // Counting the in-flight word guarantees every response finds a free slot.
        issue     = ~rst & clk_en & ~halt_q & ~redirect_valid & (occupancy < {1'b0, DepthP});
        // A response is captured even with clk_en low; only a redirect drops it.
        capture   = inflight_q & ~redirect;
        head_data = data_mem[rptr_q[AW-1:0]];
        head_pc   = pc_mem[rptr_q[AW-1:0]];
    end

    assign inst_valid   = (count != '0);
    assign pop          = inst_valid & inst_ready & clk_en & ~redirect;
    assign imem_req     = issue;
    assign imem_addr    = pc_q;
    assign inst_data    = inst_valid ? head_data : last_data_q;
    assign inst_pc      = inst_valid ? head_pc : last_pc_q;
    assign halt_seen    = halt_q;
    assign err_misalign = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            last_data_q <= '0;
            last_pc_q   <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= pc_q;
            end
            // Remember the head shown so the outputs hold steady once the queue drains.
            if (inst_valid) begin
                last_data_q <= head_data;
                last_pc_q   <= head_pc;
            end
            if (redirect) begin
                pc_q   <= {redirect_pc[31:2], 2'b00};
                wptr_q <= '0;
                rptr_q <= '0;
                halt_q <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    err_q <= 1'b1;
                end
            end else begin
                if (issue) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (capture) begin
                    wptr_q <= wptr_q + ptr_t'(1);
                    if (imem_rdata == HALT_WORD) begin
                        halt_q <= 1'b1;
                    end
                end
                if (pop) begin
                    rptr_q <= rptr_q + ptr_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            data_mem[wptr_q[AW-1:0]] <= imem_rdata;
            pc_mem[wptr_q[AW-1:0]]   <= req_pc_q;
        end
    end

`ifdef SCC_FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (capture) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redirect && (inst_valid || inflight_q)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

    no_overflow_a: assert property (@(posedge clk) disable iff (rst) capture |-> count != DepthP);

endmodule

// File: tb/tb_scc_fetch_unit.sv
// Self-checking bench for scc_fetch_unit: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_scc_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, clk_en, redirect_valid, inst_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, inst_valid, halt_seen, err_misalign;
    logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;
`ifdef SCC_FETCH_STATS_EN
    logic [31:0] fetch_count, flush_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scc_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .halt_seen      (halt_seen),
        .err_misalign   (err_misalign)
`ifdef SCC_FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
`endif
    );

    // Instruction memory: word-indexed, answers exactly one cycle after a request.
    logic [31:0] mem [256];
    logic        req_q  = 1'b0;
    logic [31:0] addr_q = '0;
    always @(posedge clk) begin
        req_q  <= imem_req;
        addr_q <= imem_addr;
    end
    assign imem_rdata = req_q ? mem[addr_q[9:2]] : 32'hDEAD_BEEF;

    // Reference model: a queue of (word, pc) plus the outstanding request.
    logic [31:0] m_pc;
    logic [31:0] q_data[$];
    logic [31:0] q_pc[$];
    bit          m_inf;
    logic [31:0] m_inf_pc;
    bit          m_halt, m_err;
    logic [31:0] m_last_d, m_last_pc;
    logic [31:0] m_fetch, m_flush;

    function automatic bit exp_req();
        return !rst && clk_en && !m_halt && !redirect_valid &&
               (q_data.size() + int'(m_inf) < int'(DEPTH));
    endfunction

    task automatic model_update();
        bit          redir, req;
        int          n;
        logic [31:0] w, old_pc;
        if (rst) begin
            m_pc = 32'h0; q_data.delete(); q_pc.delete(); m_inf = 0; m_inf_pc = 0;
            m_halt = 0; m_err = 0; m_last_d = 0; m_last_pc = 0; m_fetch = 0; m_flush = 0;
            return;
        end
        redir  = redirect_valid && clk_en;
        req    = exp_req();
        old_pc = m_pc;
        n      = q_data.size();
        if (n > 0) begin
            m_last_d  = q_data[0];
            m_last_pc = q_pc[0];
        end
        if (redir) begin
            if (n > 0 || m_inf) m_flush = m_flush + 1;
            q_data.delete();
            q_pc.delete();
            m_pc   = {redirect_pc[31:2], 2'b00};
            m_halt = 0;
            if (redirect_pc[1:0] != 2'b00) m_err = 1;
        end else begin
            if (n > 0 && inst_ready && clk_en) begin
                void'(q_data.pop_front());
                void'(q_pc.pop_front());
            end
            if (m_inf) begin
                w = mem[m_inf_pc[9:2]];
                q_data.push_back(w);
                q_pc.push_back(m_inf_pc);
                m_fetch = m_fetch + 1;
                if (w == HALT) m_halt = 1;
            end
            if (req) m_pc = m_pc + 32'd4;
        end
        m_inf = req;
        if (req) m_inf_pc = old_pc;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit e_valid;
        e_valid = (q_data.size() > 0);
        check("m_req", {31'b0, imem_req}, {31'b0, exp_req()});
        check("m_addr", imem_addr, m_pc);
        check("m_valid", {31'b0, inst_valid}, {31'b0, e_valid});
        check("m_data", inst_data, e_valid ? q_data[0] : m_last_d);
        check("m_pc", inst_pc, e_valid ? q_pc[0] : m_last_pc);
        check("m_halt", {31'b0, halt_seen}, {31'b0, m_halt});
        check("m_err", {31'b0, err_misalign}, {31'b0, m_err});
`ifdef SCC_FETCH_STATS_EN
        check("m_fetch_cnt", fetch_count, m_fetch);
        check("m_flush_cnt", flush_count, m_flush);
`endif
    endtask

    task automatic drive(input bit r, input bit en, input bit rv, input logic [31:0] rpc,
                         input bit rdy);
        @(negedge clk);
        rst            = r;
        clk_en         = en;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic step(input bit en, input bit rv, input logic [31:0] rpc, input bit rdy);
        drive(1'b0, en, rv, rpc, rdy);
        check_model();
        tick();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h123, 1'b1);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_data", inst_data, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_halt", {31'b0, halt_seen}, 32'h0);
        check("rst_err", {31'b0, err_misalign}, 32'h0);
        tick();
    endtask

    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(bit rv, logic [31:0] rpc, bit rq, logic [31:0] ad, bit v,
                                logic [31:0] pc, logic [31:0] d);
        vec_t t;
        t.rv = rv; t.rpc = rpc; t.e_req = rq; t.e_addr = ad;
        t.e_valid = v; t.e_pc = pc; t.e_data = d;
        return t;
    endfunction

    initial begin
        vec_t tbl[10];
        int   n_del;

        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | (i << 2);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        // Straight-line fetch from reset, then a redirect to 0x40 (ready held high).
        tbl[0] = mk(0, 32'h0,  1, 32'h00, 0, 32'h00, 32'h0);
        tbl[1] = mk(0, 32'h0,  1, 32'h04, 0, 32'h00, 32'h0);
        tbl[2] = mk(0, 32'h0,  1, 32'h08, 1, 32'h00, 32'h11);
        tbl[3] = mk(0, 32'h0,  1, 32'h0C, 1, 32'h04, 32'h22);
        tbl[4] = mk(0, 32'h0,  1, 32'h10, 1, 32'h08, 32'h33);
        tbl[5] = mk(0, 32'h0,  1, 32'h14, 1, 32'h0C, 32'h44);
        tbl[6] = mk(1, 32'h40, 0, 32'h18, 1, 32'h10, 32'hA000_0010);
        tbl[7] = mk(0, 32'h0,  1, 32'h40, 0, 32'h10, 32'hA000_0010);
        tbl[8] = mk(0, 32'h0,  1, 32'h44, 0, 32'h10, 32'hA000_0010);
        tbl[9] = mk(0, 32'h0,  1, 32'h48, 1, 32'h40, 32'hA000_0040);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, tbl[i].rv, tbl[i].rpc, 1'b1);
            check($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_valid});
            check($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d_data", i), inst_data, tbl[i].e_data);
            tick();
        end

        // Back-pressure: queue fills to DEPTH, fetch stalls, then drains in order.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("full_req", {31'b0, imem_req}, 32'h0);
        check("full_valid", {31'b0, inst_valid}, 32'h1);
        check("full_pc", inst_pc, 32'h0);
        check("full_addr", imem_addr, 32'h10);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check_model();
            check("drain_valid", {31'b0, inst_valid}, 32'h1);
            check("drain_pc", inst_pc, 32'(i * 4));
            check("drain_data", inst_data, mem[i]);
            if (i == 0) check("drain_req0", {31'b0, imem_req}, 32'h0);
            if (i == 1) begin
                check("drain_req1", {31'b0, imem_req}, 32'h1);
                check("drain_addr1", imem_addr, 32'h10);
            end
            tick();
        end

        // Redirect with three queued words and one in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        check("rd_pre_valid", {31'b0, inst_valid}, 32'h1);
        check("rd_pre_req", {31'b0, imem_req}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("rd_c1_valid", {31'b0, inst_valid}, 32'h0);
        check("rd_c1_req", {31'b0, imem_req}, 32'h1);
        check("rd_c1_addr", imem_addr, 32'h100);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("rd_c2_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("rd_c3_valid", {31'b0, inst_valid}, 32'h1);
        check("rd_c3_pc", inst_pc, 32'h100);
        check("rd_c3_data", inst_data, mem[64]);
        tick();

        // Halt word at 0x8.
        mem[2] = HALT;
        do_reset();
        n_del = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check_model();
            if (i == 3) check("halt_early", {31'b0, halt_seen}, 32'h0);
            if (i >= 4) begin
                check("halt_set", {31'b0, halt_seen}, 32'h1);
                check("halt_noreq", {31'b0, imem_req}, 32'h0);
            end
            if (inst_valid && n_del < 3) begin
                check("halt_drain_pc", inst_pc, 32'(n_del * 4));
                n_del++;
            end
            tick();
        end
        check("halt_drained", 32'(n_del), 32'h3);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("halt_clr", {31'b0, halt_seen}, 32'h0);
        check("halt_resume_req", {31'b0, imem_req}, 32'h1);
        check("halt_resume_addr", imem_addr, 32'h20);
        tick();
        mem[2] = 32'h33;

        // Misaligned redirect: sticky error, aligned fetch.
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h102, 1'b1);
        check("mis_pre", {31'b0, err_misalign}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("mis_err", {31'b0, err_misalign}, 32'h1);
        check("mis_req", {31'b0, imem_req}, 32'h1);
        check("mis_addr", imem_addr, 32'h100);
        tick();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("mis_valid", {31'b0, inst_valid}, 32'h1);
        check("mis_pc", inst_pc, 32'h100);
        tick();
        step(1'b1, 1'b1, 32'h200, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("mis_sticky", {31'b0, err_misalign}, 32'h1);
        check("mis_addr2", imem_addr, 32'h200);
        tick();

        // clk_en low with one request in flight.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("en_req0", {31'b0, imem_req}, 32'h1);
        check("en_addr0", imem_addr, 32'h0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check_model();
            check("en_off_req", {31'b0, imem_req}, 32'h0);
            check("en_off_addr", imem_addr, 32'h4);
            if (i >= 2) begin
                check("en_off_valid", {31'b0, inst_valid}, 32'h1);
                check("en_off_pc", inst_pc, 32'h0);
                check("en_off_data", inst_data, 32'h11);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("en_on_req", {31'b0, imem_req}, 32'h1);
        check("en_on_addr", imem_addr, 32'h4);
        check("en_on_pc", inst_pc, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 15) == 0) mem[i] = HALT;
        end
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit          r, en, rv, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            rv  = ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom & 32'h0000_03FF;
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            drive(r, en, rv, rpc, rdy);
            check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scc_fetch_unit.md
Name: scc_fetch_unit

Overview:
- Instruction fetch stage between the instruction/data memory and the scc core.
- Owns the program counter and issues one word-read request per cycle to instruction memory.
- Buffers returned words with their PC in a small prefetch FIFO and hands them to the core over a valid/ready handshake.
- Handles core redirects (branch/jump) by flushing stale words, and stops fetching once a halt word has been fetched.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding treated as halt.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- clk_en  input  1  global enable; when low, state freezes except in-flight capture.
- redirect_valid  input  1  core requests a PC change this cycle.
- redirect_pc  input  32  new fetch address.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  32  word address for the request.
- imem_rdata  input  32  read data; valid exactly one cycle after imem_req.
- inst_valid  output  1  FIFO head holds an instruction.
- inst_ready  input  1  core accepts the head this cycle.
- inst_data  output  32  head instruction word.
- inst_pc  output  32  PC of the head instruction.
- halt_seen  output  1  a halt word has entered the FIFO; fetching stopped.
- err_misalign  output  1  sticky flag: a redirect_pc had bits [1:0] not equal to 0.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - pc set to RESET_PC; FIFO emptied; in-flight flag cleared.
  - imem_req, inst_valid, halt_seen and err_misalign all 0.
  - inst_data and inst_pc read 0.
  - rst has priority over every other input, including mid-redirect and mid-flight.
- Issue rule:
  - imem_req = clk_en and not halt_seen and not redirect_valid and (count + inflight < DEPTH).
  - imem_addr = pc.
  - On issue: pc advances by 4, wrapping modulo 2^32; inflight is set to 1 for the next cycle.
- Response:
  - In the cycle after an issue, imem_rdata is written to the FIFO tail with tag pc_of_request.
  - This capture happens even if clk_en is now low.
  - The response is discarded if a redirect occurred in the issue cycle or the capture cycle (single-bit epoch).
- Dequeue: when inst_valid and inst_ready and clk_en, the head is popped. Push and pop in the same cycle leave count unchanged.
- Full: count + inflight reaching DEPTH blocks issue, so no response is ever dropped for lack of space.
- Empty: inst_valid is 0 and inst_data/inst_pc hold their last value.
- Halt:
  - When a captured word equals HALT_WORD, it is enqueued normally and halt_seen is set.
  - No further requests are made until a redirect or reset.
  - Earlier queued words still drain.
- Redirect (redirect_valid and clk_en):
  - FIFO flushed and in-flight response discarded.
  - pc set to {redirect_pc[31:2], 2'b00}; halt_seen cleared.
  - err_misalign set if redirect_pc[1:0] is not 0; it clears only on reset.
  - No issue in the redirect cycle; the first request to the new pc goes out the following cycle.
  - Redirect beats a simultaneous pop: the pop is ignored because the FIFO is flushed.
- Latency: first inst_valid appears 2 cycles after reset deassertion, or 2 cycles after a redirect. Sustained throughput is 1 instruction per cycle with inst_ready held high.
- clk_en low: pc, FIFO pointers, halt_seen and err_misalign are held; imem_req is 0; only the pending response is captured.

Optional Feature:
- Macro: SCC_FETCH_STATS_EN.
- When defined, adds two 32-bit outputs:
  - fetch_count: increments on each FIFO push.
  - flush_count: increments on each redirect that discards at least one queued or in-flight word.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, memory words at 0x0/0x4/0x8 = 0x11/0x22/0x33, inst_ready=1 -> inst_valid first at cycle 2; inst_pc sequence 0x0, 0x4, 0x8; inst_data 0x11, 0x22, 0x33 back-to-back.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 entries queued, imem_req low afterwards; then ready=1 -> entries pcs 0x0..0xC drain in order and fetching resumes at 0x10.
- Redirect to 0x100 while FIFO holds 3 entries and 1 is in flight -> no stale pc appears on inst_pc; next valid has inst_pc=0x100, 2 cycles later.
- Word at 0x8 = 0xFFFF_FFFF -> halt_seen=1 after it is captured; no imem_req afterwards; 0x0, 0x4, 0x8 still delivered; redirect to 0x20 clears halt_seen and fetching resumes.
- Redirect to 0x102 -> err_misalign=1 and stays 1; fetch proceeds at 0x100; only rst clears the flag.
- clk_en low for 5 cycles with one request in flight -> that word is captured; pc and count otherwise unchanged; imem_req=0 throughout; normal operation resumes when clk_en returns to 1.
